// File: rtl/pcpu_pkg.sv
// Shared types and constants for the PCPU hazard controller: mux3 select
// encodings and the per-stage producer record kept in the shadow pipeline.
package pcpu_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam int STG_EX  = 0;
  localparam int STG_MEM = 1;
  localparam int STG_WB  = 2;
  localparam int NUM_STG = 3;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       reg_write;
    logic       mem_read;
  } stage_info_t;

  localparam stage_info_t STAGE_BUBBLE = '0;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Signal bundle between the pipeline datapath (master) and the hazard
// controller (slave): ID-stage operand info in, forwarding/stall/flush out.
interface hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  logic             id_valid;
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic             id_rs1_used;
  logic             id_rs2_used;
  logic [4:0]       id_rd;
  logic             id_reg_write;
  logic             id_mem_read;
  logic             ex_branch_taken;
  logic             mem_stall;
  logic [1:0]       fwd_a_sel;
  logic [1:0]       fwd_b_sel;
  logic             stall_if;
  logic             stall_id;
  logic             flush_id;
  logic             flush_ex;
  logic [CNT_W-1:0] stall_count;
  logic [CNT_W-1:0] flush_count;

  modport master (
    output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
           id_rd, id_reg_write, id_mem_read, ex_branch_taken, mem_stall,
    input  fwd_a_sel, fwd_b_sel, stall_if, stall_id, flush_id, flush_ex,
           stall_count, flush_count
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
           id_rd, id_reg_write, id_mem_read, ex_branch_taken, mem_stall,
    output fwd_a_sel, fwd_b_sel, stall_if, stall_id, flush_id, flush_ex,
           stall_count, flush_count
  );
endinterface

// File: rtl/hazard_stage_reg.sv
// One shadow pipeline stage: holds while frozen, otherwise loads either the
// upstream record or a bubble.
module hazard_stage_reg
  import pcpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        hold_i,
  input  logic        bubble_i,
  input  stage_info_t d_i,
  output stage_info_t q_o
);

  stage_info_t stage_q;
  stage_info_t stage_d;

  always_comb begin
    stage_d = stage_q;
    if (!hold_i) begin
      stage_d = bubble_i ? STAGE_BUBBLE : d_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_q <= STAGE_BUBBLE;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign q_o = stage_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage PCPU: registered EX operand forwarding
// selects, load-use stall, branch flush and stall/flush event counters.
module hazard_ctrl
  import pcpu_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input logic          clk,
  input logic          rst,
  hazard_ctrl_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  stage_info_t      id_info;
  stage_info_t      stage_d [NUM_STG];
  stage_info_t      stage_q [NUM_STG];
  logic             load_use;
  logic             flush;
  logic             lu_stall;
  logic             ex_bubble;
  logic [1:0]       fwd_a_q, fwd_a_d;
  logic [1:0]       fwd_b_q, fwd_b_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  function automatic logic produces(input stage_info_t s, input logic [4:0] r);
    return s.valid && s.reg_write && (s.rd == r) && (r != 5'd0);
  endfunction

  // A load sitting in EX has no data yet; its consumer is held by load-use
  // and picks the value up from MEM on the re-evaluation.
  function automatic logic [1:0] fwd_sel(input logic [4:0] r, input logic used,
                                         input stage_info_t ex, input stage_info_t mem);
    logic [1:0] sel;
    sel = FWD_RF;
    if (used && produces(ex, r) && !ex.mem_read) begin
      sel = FWD_MEM;
    end else if (used && produces(mem, r)) begin
      sel = FWD_WB;
    end
    return sel;
  endfunction

  assign id_info = '{valid:     bus.id_valid,
                     rd:        bus.id_rd,
                     reg_write: bus.id_reg_write,
                     mem_read:  bus.id_mem_read};

  assign stage_d[STG_EX] = id_info;

  genvar gi;
  generate
    for (gi = 1; gi < NUM_STG; gi++) begin : g_chain
      assign stage_d[gi] = stage_q[gi-1];
    end
    for (gi = 0; gi < NUM_STG; gi++) begin : g_stage
      hazard_stage_reg u_stage (
        .clk      (clk),
        .rst      (rst),
        .hold_i   (bus.mem_stall),
        .bubble_i ((gi == STG_EX) ? ex_bubble : 1'b0),
        .d_i      (stage_d[gi]),
        .q_o      (stage_q[gi])
      );
    end
  endgenerate

  always_comb begin
    load_use = bus.id_valid && stage_q[STG_EX].mem_read &&
               ((bus.id_rs1_used && produces(stage_q[STG_EX], bus.id_rs1)) ||
                (bus.id_rs2_used && produces(stage_q[STG_EX], bus.id_rs2)));
  end

  assign flush     = bus.ex_branch_taken && !bus.mem_stall;
  assign lu_stall  = load_use && !flush;
  assign ex_bubble = load_use || flush;

  always_comb begin
    fwd_a_d     = fwd_a_q;
    fwd_b_d     = fwd_b_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!bus.mem_stall) begin
      fwd_a_d = ex_bubble ? FWD_RF
                          : fwd_sel(bus.id_rs1, bus.id_rs1_used, stage_q[STG_EX], stage_q[STG_MEM]);
      fwd_b_d = ex_bubble ? FWD_RF
                          : fwd_sel(bus.id_rs2, bus.id_rs2_used, stage_q[STG_EX], stage_q[STG_MEM]);
      if (lu_stall) begin
        stall_cnt_d = stall_cnt_q + CNT_ONE;
      end
      if (flush) begin
        flush_cnt_d = flush_cnt_q + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fwd_a_q     <= FWD_RF;
      fwd_b_q     <= FWD_RF;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      fwd_a_q     <= fwd_a_d;
      fwd_b_q     <= fwd_b_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign bus.fwd_a_sel   = fwd_a_q;
  assign bus.fwd_b_sel   = fwd_b_q;
  assign bus.stall_if    = bus.mem_stall || lu_stall;
  assign bus.stall_id    = bus.mem_stall || lu_stall;
  assign bus.flush_id    = flush;
  assign bus.flush_ex    = flush || lu_stall;
  assign bus.stall_count = stall_cnt_q;
  assign bus.flush_count = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scenario bench for hazard_ctrl: directed pipeline sequences plus a random
// run checked against an instruction-level model of the in-flight producers.
module tb_hazard_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hazard_ctrl_if #(.CNT_W(32)) bus ();
  hazard_ctrl #(.CNT_W(32)) dut (.clk(clk), .rst(rst), .bus(bus));

  int tests = 0;
  int fails = 0;

  // Model: the three instructions issued after ID, youngest first.
  typedef struct {
    bit valid;
    int rd;
    bit rw;
    bit ld;
  } m_instr_t;

  m_instr_t    m_pipe [3];
  logic [1:0]  m_sel_a, m_sel_b;
  logic [31:0] m_scnt, m_fcnt;

  function automatic bit m_writes(int age, int r);
    return m_pipe[age].valid && m_pipe[age].rw && (m_pipe[age].rd == r) && (r != 0);
  endfunction

  // Value source for a read of r: one ahead and not a load -> ALU result in
  // MEM (2); two ahead -> WB mux (1); otherwise the register file (0).
  function automatic logic [1:0] m_source(int r, bit used);
    if (!used) return 2'd0;
    if (m_writes(0, r) && !m_pipe[0].ld) return 2'd2;
    if (m_writes(1, r)) return 2'd1;
    return 2'd0;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) m_pipe[k] = '{valid: 0, rd: 0, rw: 0, ld: 0};
    m_sel_a = 2'd0;
    m_sel_b = 2'd0;
    m_scnt  = 32'd0;
    m_fcnt  = 32'd0;
  endtask

  task automatic drive_id(bit v, int rd, bit rw, bit ld, int rs1, bit u1, int rs2, bit u2);
    bus.id_valid     = v;
    bus.id_rd        = 5'(rd);
    bus.id_reg_write = rw;
    bus.id_mem_read  = ld;
    bus.id_rs1       = 5'(rs1);
    bus.id_rs1_used  = u1;
    bus.id_rs2       = 5'(rs2);
    bus.id_rs2_used  = u2;
  endtask

  task automatic drive_nop();
    drive_id(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    drive_nop();
    bus.ex_branch_taken = 1'b0;
    bus.mem_stall       = 1'b0;
    tick();
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive_nop();
    bus.ex_branch_taken = 1'b0;
    bus.mem_stall       = 1'b0;
    @(negedge clk);
    tests++; if (bus.fwd_a_sel !== 2'd0 || bus.fwd_b_sel !== 2'd0) begin fails++; $display("FAIL rst_sels got %0d/%0d want 0/0", bus.fwd_a_sel, bus.fwd_b_sel); end
    tests++; if (bus.stall_count !== 32'd0 || bus.flush_count !== 32'd0) begin fails++; $display("FAIL rst_counts got %0d/%0d want 0/0", bus.stall_count, bus.flush_count); end
    tests++; if ({bus.stall_if, bus.stall_id, bus.flush_id, bus.flush_ex} !== 4'b0) begin fails++; $display("FAIL rst_ctl got %b want 0000", {bus.stall_if, bus.stall_id, bus.flush_id, bus.flush_ex}); end
    tick();
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    tests++; if ({bus.stall_if, bus.stall_id, bus.flush_id, bus.flush_ex} !== 4'b0) begin fails++; $display("FAIL post_rst_ctl got %b want 0000", {bus.stall_if, bus.stall_id, bus.flush_id, bus.flush_ex}); end
    tick();
    $display("[TB] test_reset done");
  endtask

  task automatic test_ex_forward();
    reset_dut();
    drive_id(1, 5, 1, 0, 1, 1, 2, 1);             // add x5, x1, x2
    tick();
    drive_id(1, 6, 1, 0, 5, 1, 1, 1);             // sub x6, x5, x1
    @(negedge clk);
    tests++; if (bus.stall_if !== 1'b0) begin fails++; $display("FAIL exfwd_stall got %b want 0", bus.stall_if); end
    tick();
    drive_nop();
    @(negedge clk);
    tests++; if (bus.fwd_a_sel !== 2'b10) begin fails++; $display("FAIL exfwd_a got %b want 10", bus.fwd_a_sel); end
    tests++; if (bus.fwd_b_sel !== 2'b00) begin fails++; $display("FAIL exfwd_b got %b want 00", bus.fwd_b_sel); end
    tick();
    $display("[TB] test_ex_forward done");
  endtask

  task automatic test_mem_forward();
    reset_dut();
    drive_id(1, 5, 1, 0, 1, 1, 2, 1);             // add x5
    tick();
    drive_id(1, 10, 1, 0, 1, 1, 2, 1);            // independent
    tick();
    drive_id(1, 7, 1, 0, 1, 1, 5, 1);             // or x7, x1, x5
    tick();
    drive_nop();
    @(negedge clk);
    tests++; if (bus.fwd_a_sel !== 2'b00 || bus.fwd_b_sel !== 2'b01) begin fails++; $display("FAIL memfwd got %b/%b want 00/01", bus.fwd_a_sel, bus.fwd_b_sel); end
    reset_dut();
    drive_id(1, 5, 1, 0, 1, 1, 2, 1);
    tick();
    drive_id(1, 10, 1, 0, 1, 1, 2, 1);
    tick();
    drive_id(1, 8, 1, 0, 5, 1, 5, 1);             // add x8, x5, x5
    tick();
    drive_nop();
    @(negedge clk);
    tests++; if (bus.fwd_a_sel !== 2'b01 || bus.fwd_b_sel !== 2'b01) begin fails++; $display("FAIL memfwd_both got %b/%b want 01/01", bus.fwd_a_sel, bus.fwd_b_sel); end
    tick();
    $display("[TB] test_mem_forward done");
  endtask

  task automatic test_load_use();
    reset_dut();
    drive_id(1, 8, 1, 1, 2, 1, 0, 0);             // lw x8, 0(x2)
    tick();
    drive_id(1, 9, 1, 0, 8, 1, 8, 1);             // add x9, x8, x8
    @(negedge clk);
    tests++; if ({bus.stall_if, bus.stall_id, bus.flush_ex, bus.flush_id} !== 4'b1110) begin fails++; $display("FAIL lu_ctl got %b want 1110", {bus.stall_if, bus.stall_id, bus.flush_ex, bus.flush_id}); end
    tick();
    @(negedge clk);
    tests++; if ({bus.stall_if, bus.stall_id, bus.flush_ex} !== 3'b000) begin fails++; $display("FAIL lu_one_bubble got %b want 000", {bus.stall_if, bus.stall_id, bus.flush_ex}); end
    tick();
    drive_nop();
    @(negedge clk);
    tests++; if (bus.fwd_a_sel !== 2'b01 || bus.fwd_b_sel !== 2'b01) begin fails++; $display("FAIL lu_sels got %b/%b want 01/01", bus.fwd_a_sel, bus.fwd_b_sel); end
    tests++; if (bus.stall_count !== 32'd1) begin fails++; $display("FAIL lu_count got %0d want 1", bus.stall_count); end
    tick();
    $display("[TB] test_load_use done");
  endtask

  task automatic test_back_to_back();
    reset_dut();
    drive_id(1, 8, 1, 1, 2, 1, 0, 0);             // lw x8
    tick();
    drive_id(1, 9, 1, 1, 8, 1, 0, 0);             // lw x9, 0(x8)
    @(negedge clk);
    tests++; if (bus.stall_if !== 1'b1) begin fails++; $display("FAIL b2b_stall1 got %b want 1", bus.stall_if); end
    tick();
    @(negedge clk);
    tests++; if (bus.stall_if !== 1'b0) begin fails++; $display("FAIL b2b_release1 got %b want 0", bus.stall_if); end
    tick();
    drive_id(1, 10, 1, 0, 9, 1, 0, 0);            // add x10, x9, x0
    @(negedge clk);
    tests++; if (bus.stall_if !== 1'b1) begin fails++; $display("FAIL b2b_stall2 got %b want 1", bus.stall_if); end
    tick();
    @(negedge clk);
    tests++; if (bus.stall_if !== 1'b0) begin fails++; $display("FAIL b2b_release2 got %b want 0", bus.stall_if); end
    tick();
    drive_nop();
    @(negedge clk);
    tests++; if (bus.stall_count !== 32'd2 || bus.fwd_a_sel !== 2'b01) begin fails++; $display("FAIL b2b_end got cnt=%0d sel=%b want cnt=2 sel=01", bus.stall_count, bus.fwd_a_sel); end
    tick();
    $display("[TB] test_back_to_back done");
  endtask

  task automatic test_x0_unused();
    reset_dut();
    drive_id(1, 0, 1, 0, 1, 1, 2, 1);             // add x0, x1, x2
    tick();
    drive_id(1, 4, 1, 0, 0, 1, 0, 1);             // add x4, x0, x0
    tick();
    drive_id(1, 0, 1, 1, 2, 1, 0, 0);             // lw x0
    @(negedge clk);
    tests++; if (bus.fwd_a_sel !== 2'b00 || bus.fwd_b_sel !== 2'b00) begin fails++; $display("FAIL x0_sels got %b/%b want 00/00", bus.fwd_a_sel, bus.fwd_b_sel); end
    tick();
    drive_id(1, 4, 1, 0, 0, 1, 0, 1);
    @(negedge clk);
    tests++; if (bus.stall_if !== 1'b0) begin fails++; $display("FAIL x0_load_stall got %b want 0", bus.stall_if); end
    tick();
    drive_id(1, 3, 1, 0, 1, 1, 2, 1);             // add x3
    tick();
    drive_id(1, 6, 1, 0, 3, 0, 3, 0);             // rs match but unused
    tick();
    drive_nop();
    @(negedge clk);
    tests++; if (bus.fwd_a_sel !== 2'b00 || bus.fwd_b_sel !== 2'b00) begin fails++; $display("FAIL unused_sels got %b/%b want 00/00", bus.fwd_a_sel, bus.fwd_b_sel); end
    tests++; if (bus.stall_count !== 32'd0) begin fails++; $display("FAIL x0_count got %0d want 0", bus.stall_count); end
    tick();
    $display("[TB] test_x0_unused done");
  endtask

  task automatic test_branch_flush();
    reset_dut();
    drive_id(1, 8, 1, 1, 2, 1, 0, 0);
    tick();
    drive_id(1, 9, 1, 0, 8, 1, 8, 1);
    bus.ex_branch_taken = 1'b1;
    @(negedge clk);
    tests++; if ({bus.flush_id, bus.flush_ex, bus.stall_if, bus.stall_id} !== 4'b1100) begin fails++; $display("FAIL br_ctl got %b want 1100", {bus.flush_id, bus.flush_ex, bus.stall_if, bus.stall_id}); end
    tick();
    bus.ex_branch_taken = 1'b0;
    drive_nop();
    @(negedge clk);
    tests++; if (bus.flush_count !== 32'd1 || bus.stall_count !== 32'd0) begin fails++; $display("FAIL br_counts got %0d/%0d want 1/0", bus.flush_count, bus.stall_count); end
    tests++; if (bus.fwd_a_sel !== 2'b00 || bus.flush_id !== 1'b0) begin fails++; $display("FAIL br_after got sel=%b fid=%b want 00/0", bus.fwd_a_sel, bus.flush_id); end
    tick();
    $display("[TB] test_branch_flush done");
  endtask

  task automatic test_freeze();
    reset_dut();
    drive_id(1, 8, 1, 1, 2, 1, 0, 0);
    tick();
    drive_id(1, 9, 1, 0, 8, 1, 8, 1);
    bus.mem_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests++; if (bus.stall_if !== 1'b1 || bus.stall_id !== 1'b1 || bus.stall_count !== 32'd0) begin fails++; $display("FAIL frz_cycle%0d got si=%b sd=%b cnt=%0d want 1/1/0", i, bus.stall_if, bus.stall_id, bus.stall_count); end
      tick();
    end
    bus.mem_stall = 1'b0;
    @(negedge clk);
    tests++; if (bus.stall_if !== 1'b1 || bus.flush_ex !== 1'b1) begin fails++; $display("FAIL frz_release got si=%b fe=%b want 1/1", bus.stall_if, bus.flush_ex); end
    tick();
    @(negedge clk);
    tests++; if (bus.stall_if !== 1'b0 || bus.stall_count !== 32'd1) begin fails++; $display("FAIL frz_bubble got si=%b cnt=%0d want 0/1", bus.stall_if, bus.stall_count); end
    tick();
    drive_nop();
    bus.ex_branch_taken = 1'b1;
    bus.mem_stall       = 1'b1;
    @(negedge clk);
    tests++; if (bus.fwd_a_sel !== 2'b01 || bus.flush_id !== 1'b0) begin fails++; $display("FAIL frz_br got sel=%b fid=%b want 01/0", bus.fwd_a_sel, bus.flush_id); end
    tick();
    bus.mem_stall = 1'b0;
    @(negedge clk);
    tests++; if (bus.flush_id !== 1'b1 || bus.flush_ex !== 1'b1) begin fails++; $display("FAIL frz_br_release got %b%b want 11", bus.flush_id, bus.flush_ex); end
    tick();
    bus.ex_branch_taken = 1'b0;
    @(negedge clk);
    tests++; if (bus.flush_count !== 32'd1) begin fails++; $display("FAIL frz_fcount got %0d want 1", bus.flush_count); end
    tick();
    $display("[TB] test_freeze done");
  endtask

  task automatic test_reset_mid();
    reset_dut();
    drive_id(1, 8, 1, 1, 2, 1, 0, 0);
    tick();
    drive_id(1, 9, 1, 0, 8, 1, 8, 1);
    tick();
    tick();
    drive_id(1, 11, 1, 0, 9, 1, 0, 0);            // reader of x9 while add x9 in EX
    tests++; if (bus.fwd_a_sel !== 2'b01 || bus.stall_count !== 32'd1) begin fails++; $display("FAIL mid_pre got sel=%b cnt=%0d want 01/1", bus.fwd_a_sel, bus.stall_count); end
    #1;
    rst = 1'b1;
    #1;
    tests++; if (bus.fwd_a_sel !== 2'b00 || bus.fwd_b_sel !== 2'b00 || bus.stall_count !== 32'd0 || bus.flush_count !== 32'd0) begin fails++; $display("FAIL mid_async got %b/%b cnt=%0d/%0d want 00/00 0/0", bus.fwd_a_sel, bus.fwd_b_sel, bus.stall_count, bus.flush_count); end
    tests++; if ({bus.stall_if, bus.stall_id, bus.flush_id, bus.flush_ex} !== 4'b0) begin fails++; $display("FAIL mid_async_ctl got %b want 0000", {bus.stall_if, bus.stall_id, bus.flush_id, bus.flush_ex}); end
    #1;
    rst = 1'b0;
    tick();
    @(negedge clk);
    tests++; if (bus.fwd_a_sel !== 2'b00) begin fails++; $display("FAIL mid_discard got %b want 00", bus.fwd_a_sel); end
    tick();
    $display("[TB] test_reset_mid done");
  endtask

  task automatic test_random(int n);
    m_instr_t idi;
    int rs1, rs2;
    bit u1, u2, br, ms, lu, fl;
    logic [1:0] na, nb;
    reset_dut();
    for (int c = 0; c < n; c++) begin
      idi.valid = ($urandom_range(0, 9) != 0);
      idi.rd    = $urandom_range(0, 3);
      idi.rw    = ($urandom_range(0, 3) != 0);
      idi.ld    = ($urandom_range(0, 2) == 0);
      rs1 = $urandom_range(0, 3);
      rs2 = $urandom_range(0, 3);
      u1  = ($urandom_range(0, 3) != 0);
      u2  = ($urandom_range(0, 3) != 0);
      br  = ($urandom_range(0, 9) == 0);
      ms  = ($urandom_range(0, 4) == 0);
      drive_id(idi.valid, idi.rd, idi.rw, idi.ld, rs1, u1, rs2, u2);
      bus.ex_branch_taken = br;
      bus.mem_stall       = ms;
      lu = idi.valid && m_pipe[0].ld && ((u1 && m_writes(0, rs1)) || (u2 && m_writes(0, rs2)));
      fl = br && !ms;
      @(negedge clk);
      tests++; if (bus.stall_if !== (ms || (lu && !fl)) || bus.stall_id !== (ms || (lu && !fl))) begin fails++; $display("FAIL rnd_stall c=%0d got %b%b want %b", c, bus.stall_if, bus.stall_id, ms || (lu && !fl)); end
      tests++; if (bus.flush_id !== fl || bus.flush_ex !== (fl || lu)) begin fails++; $display("FAIL rnd_flush c=%0d got %b%b want %b%b", c, bus.flush_id, bus.flush_ex, fl, fl || lu); end
      tests++; if (bus.fwd_a_sel !== m_sel_a || bus.fwd_b_sel !== m_sel_b) begin fails++; $display("FAIL rnd_sels c=%0d got %b/%b want %b/%b", c, bus.fwd_a_sel, bus.fwd_b_sel, m_sel_a, m_sel_b); end
      tests++; if (bus.stall_count !== m_scnt || bus.flush_count !== m_fcnt) begin fails++; $display("FAIL rnd_counts c=%0d got %0d/%0d want %0d/%0d", c, bus.stall_count, bus.flush_count, m_scnt, m_fcnt); end
      if (!ms) begin
        na = (lu || fl) ? 2'd0 : m_source(rs1, u1);
        nb = (lu || fl) ? 2'd0 : m_source(rs2, u2);
        m_sel_a = na;
        m_sel_b = nb;
        m_pipe[2] = m_pipe[1];
        m_pipe[1] = m_pipe[0];
        if (lu || fl) m_pipe[0] = '{valid: 0, rd: 0, rw: 0, ld: 0};
        else          m_pipe[0] = idi;
        if (lu && !fl) m_scnt = m_scnt + 32'd1;
        if (fl)        m_fcnt = m_fcnt + 32'd1;
      end
      tick();
    end
    $display("[TB] test_random done: %0d cycles, stalls=%0d flushes=%0d", n, m_scnt, m_fcnt);
  endtask

  initial begin
    test_reset();
    test_ex_forward();
    test_mem_forward();
    test_load_use();
    test_back_to_back();
    test_x0_unused();
    test_branch_flush();
    test_freeze();
    test_reset_mid();
    test_random(600);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
